alu_instr_sequencer: RTL and testbench

- Parametrised control sequencer that replaces hand-coded per-instruction T-state control.
- Drives the datapath's bus select, register-enable, PC-increment, memory-read and ALU-op controls through fetch (T0–T2) and execute/writeback.
- Covers reg-reg ALU, unary, and multi-cycle MUL/DIV (HI/LO) instructions.
- Adds start/busy/done handshake, free-run mode and illegal-opcode trap.

---
 rtl/alu_instr_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Control sequencer for a bus-based datapath: fetch (T0-T2), decode, execute, writeback.
// Ports: clock/clear, start/run handshake, ir; bus select, register enables, incPC,
// MDR_read, ALU_op, busy/done/illegal status. All outputs are registered Moore outputs.
module alu_instr_sequencer #(
   parameter int         REGW   = 4,
   parameter int         ALUW   = 4,
   parameter logic [4:0] OP_MUL = 5'h0F,
   parameter logic [4:0] OP_DIV = 5'h10,
   parameter logic [4:0] OP_NEG = 5'h11,
   parameter logic [4:0] OP_NOT = 5'h12,
   parameter int         MD_LAT = 4
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            start,
   input  logic            run,
   input  logic [31:0]     ir,
   output logic [4:0]      BusDataSelect,
   output logic [REGW-1:0] GP_addr,
   output logic            e_PC,
   output logic            e_IR,
   output logic            e_Y,
   output logic            e_Z,
   output logic            e_HI,
   output logic            e_LO,
   output logic            e_MDR,
   output logic            e_MAR,
   output logic            e_GP,
   output logic            incPC,
   output logic            MDR_read,
   output logic [ALUW-1:0] ALU_op,
   output logic            busy,
   output logic            done,
   output logic            illegal
);

   // Bus source codes (HI/LO read-back codes 10000/10001 are not used by this sequencer).
   localparam logic [4:0] SEL_ZHI = 5'b10010;
   localparam logic [4:0] SEL_ZLO = 5'b10011;
   localparam logic [4:0] SEL_PC  = 5'b10100;
   localparam logic [4:0] SEL_MDR = 5'b10101;

   localparam int            CW       = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_LAT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T4W,
      S_T5, S_T5M, S_T6, S_DONE, S_TRAP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // IR field decode
   logic [4:0]      opc;
   logic [REGW-1:0] ra, rb, rc;
   logic            is_rr, is_md, is_un;
   logic            unused_ir;

   assign opc       = ir[31:27];
   assign ra        = ir[23 +: REGW];
   assign rb        = ir[19 +: REGW];
   assign rc        = ir[15 +: REGW];
   assign is_rr     = (opc < OP_MUL);
   assign is_md     = (opc == OP_MUL) || (opc == OP_DIV);
   assign is_un     = (opc == OP_NEG) || (opc == OP_NOT);
   assign unused_ir = ^ir[14:0];

   // Each branch assigns the outputs belonging to the state being entered, so the
   // registered outputs always line up with the state register.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state         <= S_IDLE;
         cnt           <= '0;
         BusDataSelect <= '0;
         GP_addr       <= '0;
         e_PC  <= 1'b0; e_IR  <= 1'b0; e_Y   <= 1'b0; e_Z   <= 1'b0;
         e_HI  <= 1'b0; e_LO  <= 1'b0; e_MDR <= 1'b0; e_MAR <= 1'b0;
         e_GP  <= 1'b0;
         incPC    <= 1'b0;
         MDR_read <= 1'b0;
         ALU_op   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         // Enables are single-cycle pulses; ALU_op deliberately has no default (it holds).
         BusDataSelect <= '0;
         GP_addr       <= '0;
         e_PC  <= 1'b0; e_IR  <= 1'b0; e_Y   <= 1'b0; e_Z   <= 1'b0;
         e_HI  <= 1'b0; e_LO  <= 1'b0; e_MDR <= 1'b0; e_MAR <= 1'b0;
         e_GP  <= 1'b0;
         incPC    <= 1'b0;
         MDR_read <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;

         case (state)
            // start is honoured only in IDLE; after DONE/TRAP only run chains a fetch
            S_IDLE, S_DONE, S_TRAP: begin
               if ((state == S_IDLE) ? start : run) begin
                  state         <= S_T0;
                  busy          <= 1'b1;
                  BusDataSelect <= SEL_PC;
                  e_MAR         <= 1'b1;
                  incPC         <= 1'b1;
                  e_Z           <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_T0: begin
               state         <= S_T1;
               busy          <= 1'b1;
               BusDataSelect <= SEL_ZLO;
               e_PC          <= 1'b1;
               MDR_read      <= 1'b1;
               e_MDR         <= 1'b1;
            end
            S_T1: begin
               state         <= S_T2;
               busy          <= 1'b1;
               BusDataSelect <= SEL_MDR;
               e_IR          <= 1'b1;
            end
            S_T2: begin
               busy <= 1'b1;
               if (is_un) begin
                  // unary ops need no Y operand, so T3 is bypassed
                  state         <= S_T4;
                  BusDataSelect <= 5'(rb);
                  ALU_op        <= opc[ALUW-1:0];
               end else begin
                  // illegal opcodes still spend one quiet T3 cycle before trapping
                  state <= S_T3;
                  if (is_rr || is_md) begin
                     BusDataSelect <= 5'(rb);
                     e_Y           <= 1'b1;
                  end
               end
            end
            S_T3: begin
               if (is_rr) begin
                  state         <= S_T4;
                  busy          <= 1'b1;
                  BusDataSelect <= 5'(rc);
                  ALU_op        <= opc[ALUW-1:0];
                  e_Z           <= 1'b1;
               end else if (is_md) begin
                  state         <= S_T4W;
                  busy          <= 1'b1;
                  cnt           <= '0;
                  BusDataSelect <= 5'(rc);
                  ALU_op        <= opc[ALUW-1:0];
                  e_Z           <= (MD_LAT == 1);
               end else begin
                  state   <= S_TRAP;
                  done    <= 1'b1;
                  illegal <= 1'b1;
               end
            end
            S_T4: begin
               state         <= S_T5;
               busy          <= 1'b1;
               BusDataSelect <= SEL_ZLO;
               GP_addr       <= ra;
               e_GP          <= 1'b1;
            end
            S_T4W: begin
               busy <= 1'b1;
               if (cnt == CNT_LAST) begin
                  state         <= S_T5M;
                  BusDataSelect <= SEL_ZLO;
                  e_LO          <= 1'b1;
               end else begin
                  // operands stay on the bus; Z captures only on the final wait cycle
                  cnt           <= cnt + 1'b1;
                  BusDataSelect <= 5'(rc);
                  e_Z           <= (CW'(cnt + 1'b1) == CNT_LAST);
               end
            end
            S_T5M: begin
               state         <= S_T6;
               busy          <= 1'b1;
               BusDataSelect <= SEL_ZHI;
               e_HI          <= 1'b1;
            end
            S_T5, S_T6: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;

   localparam int MD_LAT = 4;

   logic        clock = 1'b0;
   logic        clear, start, run;
   logic [31:0] ir;
   logic [4:0]  BusDataSelect;
   logic [3:0]  GP_addr, ALU_op;
   logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
   logic        incPC, MDR_read, busy, done, illegal;

   always #5 clock = ~clock;

   alu_instr_sequencer #(.MD_LAT(MD_LAT)) dut (
      .clock(clock), .clear(clear), .start(start), .run(run), .ir(ir),
      .BusDataSelect(BusDataSelect), .GP_addr(GP_addr),
      .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
      .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
      .incPC(incPC), .MDR_read(MDR_read), .ALU_op(ALU_op),
      .busy(busy), .done(done), .illegal(illegal)
   );

   // enable vector order: {PC,IR,Y,Z,HI,LO,MDR,MAR,GP}
   localparam logic [8:0] EN_PC  = 9'b100000000;
   localparam logic [8:0] EN_IR  = 9'b010000000;
   localparam logic [8:0] EN_Y   = 9'b001000000;
   localparam logic [8:0] EN_Z   = 9'b000100000;
   localparam logic [8:0] EN_HI  = 9'b000010000;
   localparam logic [8:0] EN_LO  = 9'b000001000;
   localparam logic [8:0] EN_MDR = 9'b000000100;
   localparam logic [8:0] EN_MAR = 9'b000000010;
   localparam logic [8:0] EN_GP  = 9'b000000001;

   typedef struct packed {
      logic [4:0] sel;
      logic [3:0] gpa;
      logic [3:0] alu;
      logic [8:0] en;
      logic       inc, mrd, bsy, dn, ill;
   } vec_t;

   typedef struct packed {
      logic [31:0] ir;
      logic        run;
      vec_t        v;
   } entry_t;

   entry_t     q[$];
   logic [3:0] alu_m;
   int         vectors = 0;
   int         miscompares = 0;

   function automatic vec_t mk(input logic [4:0] s, input logic [8:0] e, input logic [3:0] g,
                               input logic [3:0] a, input logic inc, input logic mrd,
                               input logic bsy, input logic dn, input logic il);
      vec_t v;
      v.sel = s; v.en = e; v.gpa = g; v.alu = a;
      v.inc = inc; v.mrd = mrd; v.bsy = bsy; v.dn = dn; v.ill = il;
      return v;
   endfunction

   function automatic vec_t obs();
      vec_t v;
      v.sel = BusDataSelect; v.gpa = GP_addr; v.alu = ALU_op;
      v.en  = {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP};
      v.inc = incPC; v.mrd = MDR_read; v.bsy = busy; v.dn = done; v.ill = illegal;
      return v;
   endfunction

   // done latency counted in clocks from the edge that samples start
   function automatic int lat(input logic [4:0] op);
      if (op == 5'h11 || op == 5'h12) return 6;
      if (op < 5'h0F)                 return 7;
      if (op <= 5'h10)                return 7 + MD_LAT;
      return 5;
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push(input logic [31:0] i, input logic r, input vec_t v);
      entry_t e;
      e.ir = i; e.run = r; e.v = v;
      q.push_back(e);
   endtask

   // Expected per-cycle output trace of one instruction, written from the state list.
   task automatic model(input logic [31:0] i, input logic r);
      logic [4:0] op = i[31:27];
      logic [3:0] ra = i[26:23];
      logic [3:0] rb = i[22:19];
      logic [3:0] rc = i[18:15];
      push(i, r, mk(5'h14, EN_MAR | EN_Z, 4'd0, alu_m, 1, 0, 1, 0, 0));
      push(i, r, mk(5'h13, EN_PC | EN_MDR, 4'd0, alu_m, 0, 1, 1, 0, 0));
      push(i, r, mk(5'h15, EN_IR, 4'd0, alu_m, 0, 0, 1, 0, 0));
      if (op == 5'h11 || op == 5'h12) begin
         alu_m = op[3:0];
         push(i, r, mk({1'b0, rb}, 9'd0, 4'd0, alu_m, 0, 0, 1, 0, 0));
         push(i, r, mk(5'h13, EN_GP, ra, alu_m, 0, 0, 1, 0, 0));
         push(i, r, mk(5'h00, 9'd0, 4'd0, alu_m, 0, 0, 0, 1, 0));
      end else if (op <= 5'h10) begin
         push(i, r, mk({1'b0, rb}, EN_Y, 4'd0, alu_m, 0, 0, 1, 0, 0));
         alu_m = op[3:0];
         if (op < 5'h0F) begin
            push(i, r, mk({1'b0, rc}, EN_Z, 4'd0, alu_m, 0, 0, 1, 0, 0));
            push(i, r, mk(5'h13, EN_GP, ra, alu_m, 0, 0, 1, 0, 0));
         end else begin
            for (int k = 0; k < MD_LAT; k++)
               push(i, r, mk({1'b0, rc}, (k == MD_LAT-1) ? EN_Z : 9'd0, 4'd0, alu_m, 0, 0, 1, 0, 0));
            push(i, r, mk(5'h13, EN_LO, 4'd0, alu_m, 0, 0, 1, 0, 0));
            push(i, r, mk(5'h12, EN_HI, 4'd0, alu_m, 0, 0, 1, 0, 0));
         end
         push(i, r, mk(5'h00, 9'd0, 4'd0, alu_m, 0, 0, 0, 1, 0));
      end else begin
         push(i, r, mk(5'h00, 9'd0, 4'd0, alu_m, 0, 0, 1, 0, 0));
         push(i, r, mk(5'h00, 9'd0, 4'd0, alu_m, 0, 0, 0, 1, 1));
      end
   endtask

   task automatic tail();
      push(32'd0, 1'b0, mk(5'h00, 9'd0, 4'd0, alu_m, 0, 0, 0, 0, 0));
   endtask

   // Plays the queued trace: start is raised only before the first edge. Called at a negedge.
   task automatic play(input string name, input logic check_lat);
      int         first_done = -1;
      logic [4:0] op0 = q[0].ir[31:27];
      for (int k = 0; k < q.size(); k++) begin
         ir    = q[k].ir;
         run   = q[k].run;
         start = (k == 0);
         @(posedge clock);
         @(negedge clock);
         start = 1'b0;
         if (done && first_done < 0) first_done = k + 1;
         chk($sformatf("%s_c%0d", name, k), 64'(obs()), 64'(q[k].v));
      end
      if (check_lat)
         chk($sformatf("%s_latency", name), 64'(first_done), 64'(lat(op0)));
      q.delete();
   endtask

   initial begin
      logic [31:0] ri;
      clear = 1'b1; start = 1'b0; run = 1'b0; ir = 32'd0; alu_m = 4'd0;
      repeat (2) @(negedge clock);
      chk("reset", 64'(obs()), 64'(mk(5'h00, 9'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0)));
      clear = 1'b0;
      @(negedge clock);

      model(32'h2A308000, 1'b0); tail(); play("regreg", 1);
      model({5'h0F, 4'd2, 4'd7, 4'd9, 15'd0}, 1'b0); tail(); play("mul", 1);
      model({5'h10, 4'd8, 4'd1, 4'd14, 15'h1234}, 1'b0); tail(); play("div", 1);
      model({5'h11, 4'd5, 4'd3, 4'd0, 15'd0}, 1'b0); tail(); play("neg", 1);
      model({5'h1F, 4'd6, 4'd2, 4'd3, 15'd0}, 1'b0); tail(); play("illegal", 1);

      // free-run chaining: second T0 directly follows the first DONE
      model(32'h2A308000, 1'b1); model({5'h03, 4'd9, 4'd10, 4'd11, 15'd0}, 1'b1);
      tail(); play("chain", 0);

      // asynchronous clear in T4 of a reg-reg instruction
      ir = 32'h2A308000; start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clock);
         @(negedge clock);
         start = 1'b0;
      end
      clear = 1'b1;
      #1;
      chk("clear_async", 64'(obs()), 64'(mk(5'h00, 9'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0)));
      @(posedge clock);
      @(negedge clock);
      clear = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("clear_idle", 64'(obs()), 64'(mk(5'h00, 9'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0)));
      alu_m = 4'd0;
      model(32'h2A308000, 1'b0); tail(); play("after_clear", 1);

      // random single instructions across all opcode classes
      for (int n = 0; n < 24; n++) begin
         ri = $urandom;
         model(ri, 1'b0); tail(); play($sformatf("rnd%0d", n), 1);
      end

      // random free-run chain of three
      for (int n = 0; n < 3; n++) begin
         ri = $urandom;
         model(ri, 1'b1);
      end
      tail(); play("rndchain", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
